// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer for the 16-bit pipelined core.
// Define INT_NESTING_EN to allow nested entry up to MAX_DEPTH levels.
module interrupt_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH = 32,
  parameter int FLAG_WIDTH = 3,
  parameter int unsigned VEC_ADDR = 0,
  parameter int MAX_DEPTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  interruptSignal,
  input  logic                  instr_boundary,
  input  logic                  rti_decoded,
  input  logic [PC_WIDTH-1:0]   pc_ret,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_sp_sel,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_load_value,
  output logic                  flags_load,
  output logic [FLAG_WIDTH-1:0] flags_value,
  output logic                  int_active,
  output logic [3:0]            dbg_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PUSH_HI  = 4'd1;
  localparam logic [3:0] S_PUSH_LO  = 4'd2;
  localparam logic [3:0] S_PUSH_FLG = 4'd3;
  localparam logic [3:0] S_VEC_HI   = 4'd4;
  localparam logic [3:0] S_VEC_LO   = 4'd5;
  localparam logic [3:0] S_JUMP     = 4'd6;
  localparam logic [3:0] S_POP_FLG  = 4'd7;
  localparam logic [3:0] S_POP_LO   = 4'd8;
  localparam logic [3:0] S_POP_HI   = 4'd9;
  localparam logic [3:0] S_RET_JUMP = 4'd10;

  localparam logic [2:0]          L_MAX         = 3'(MAX_DEPTH);
  localparam logic [PC_WIDTH-1:0] L_VEC_HI_ADDR = PC_WIDTH'(VEC_ADDR);
  localparam logic [PC_WIDTH-1:0] L_VEC_LO_ADDR = PC_WIDTH'(VEC_ADDR + 1);

  logic [3:0]            r_state;
  logic [3:0]            w_state_nxt;
  logic                  r_int_prev;
  logic                  r_pending;
  logic [2:0]            r_depth;
  logic [PC_WIDTH-1:0]   r_pc_save;
  logic [FLAG_WIDTH-1:0] r_flags_save;
  logic [DATA_WIDTH-1:0] r_vec_hi;
  logic [DATA_WIDTH-1:0] r_vec_lo;
  logic [FLAG_WIDTH-1:0] r_pop_flags;
  logic [DATA_WIDTH-1:0] r_pop_lo;
  logic [DATA_WIDTH-1:0] r_pop_hi;

  logic w_edge;
  logic w_depth_ok;
  logic w_accept;
  logic w_take_rti;
  logic w_take_int;

  assign w_edge = interruptSignal & ~r_int_prev;

`ifdef INT_NESTING_EN
  assign w_depth_ok = (r_depth < L_MAX);
`else
  assign w_depth_ok = (r_depth == 3'd0);
`endif

  // RTI has priority in IDLE; an accepted-but-preempted request simply stays pending.
  assign w_accept   = r_pending & instr_boundary & w_depth_ok;
  assign w_take_rti = (r_state == S_IDLE) & rti_decoded;
  assign w_take_int = (r_state == S_IDLE) & ~rti_decoded & w_accept;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (rti_decoded)   w_state_nxt = S_POP_FLG;
        else if (w_accept) w_state_nxt = S_PUSH_HI;
      end
      S_PUSH_HI:  if (mem_ack) w_state_nxt = S_PUSH_LO;
      S_PUSH_LO:  if (mem_ack) w_state_nxt = S_PUSH_FLG;
      S_PUSH_FLG: if (mem_ack) w_state_nxt = S_VEC_HI;
      S_VEC_HI:   if (mem_ack) w_state_nxt = S_VEC_LO;
      S_VEC_LO:   if (mem_ack) w_state_nxt = S_JUMP;
      S_JUMP:     w_state_nxt = S_IDLE;
      S_POP_FLG:  if (mem_ack) w_state_nxt = S_POP_LO;
      S_POP_LO:   if (mem_ack) w_state_nxt = S_POP_HI;
      S_POP_HI:   if (mem_ack) w_state_nxt = S_RET_JUMP;
      S_RET_JUMP: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_int_prev   <= 1'b0;
      r_pending    <= 1'b0;
      r_depth      <= 3'd0;
      r_pc_save    <= '0;
      r_flags_save <= '0;
      r_vec_hi     <= '0;
      r_vec_lo     <= '0;
      r_pop_flags  <= '0;
      r_pop_lo     <= '0;
      r_pop_hi     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_int_prev <= interruptSignal;
      // A fresh edge in the accept cycle is a new request and keeps pending set.
      r_pending  <= w_edge | (r_pending & ~w_take_int);
      if (w_take_int) begin
        r_pc_save    <= pc_ret;
        r_flags_save <= flags_in;
      end
      if (mem_ack) begin
        case (r_state)
          S_VEC_HI:  r_vec_hi    <= mem_rdata;
          S_VEC_LO:  r_vec_lo    <= mem_rdata;
          S_POP_FLG: r_pop_flags <= mem_rdata[FLAG_WIDTH-1:0];
          S_POP_LO:  r_pop_lo    <= mem_rdata;
          S_POP_HI:  r_pop_hi    <= mem_rdata;
          default: ;
        endcase
      end
      if ((r_state == S_JUMP) && (r_depth != L_MAX)) r_depth <= r_depth + 3'd1;
      if ((r_state == S_RET_JUMP) && (r_depth != 3'd0)) r_depth <= r_depth - 3'd1;
    end
  end

  // Memory handshake: mem_req and its qualifiers (mem_we, mem_sp_sel, mem_addr,
  // mem_wdata) hold steady until mem_ack; the access completes in the ack cycle.
  always_comb begin
    stall         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sp_sel    = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    flags_load    = 1'b0;
    flags_value   = '0;
    int_active    = 1'b0;
    dbg_state     = 4'd0;
    if (!reset) begin
      dbg_state  = r_state;
      int_active = (r_depth != 3'd0);
      stall      = (r_state != S_IDLE) | w_take_rti | w_take_int;
      case (r_state)
        S_PUSH_HI: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_sp_sel = 1'b1;
          mem_wdata  = r_pc_save[PC_WIDTH-1 -: DATA_WIDTH];
        end
        S_PUSH_LO: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_sp_sel = 1'b1;
          mem_wdata  = r_pc_save[DATA_WIDTH-1:0];
        end
        S_PUSH_FLG: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_sp_sel = 1'b1;
          mem_wdata  = {{(DATA_WIDTH-FLAG_WIDTH){1'b0}}, r_flags_save};
        end
        S_VEC_HI: begin
          mem_req  = 1'b1;
          mem_addr = L_VEC_HI_ADDR;
        end
        S_VEC_LO: begin
          mem_req  = 1'b1;
          mem_addr = L_VEC_LO_ADDR;
        end
        S_JUMP: begin
          pc_load       = 1'b1;
          pc_load_value = {r_vec_hi, r_vec_lo};
        end
        S_POP_FLG, S_POP_LO, S_POP_HI: begin
          mem_req    = 1'b1;
          mem_sp_sel = 1'b1;
        end
        S_RET_JUMP: begin
          pc_load       = 1'b1;
          pc_load_value = {r_pop_hi, r_pop_lo};
          flags_load    = 1'b1;
          flags_value   = r_pop_flags;
        end
        default: ;
      endcase
    end
  end

endmodule
